fifo_wptr_full: RTL

//  Write-side pointer and flag logic of the async sample FIFO. Owns the binary/Gray write pointer,

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_gray2bin.sv | 17 +
 rtl/fifo_wptr_full.sv | 88 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks (write and read side).
// Conversions work on 32-bit zero-extended values so any pointer width up to 32 can use them.
package fifo_pkg;

  localparam int unsigned ADDR_SIZE_DEFAULT = 8;
  localparam int unsigned DEPTH_DEFAULT     = 2 ** ADDR_SIZE_DEFAULT;

  function automatic int unsigned fifo_depth(input int unsigned addr_size);
    return 2 ** addr_size;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of parameterisable width.
module fifo_gray2bin #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag logic of the async sample FIFO: Gray write pointer,
// RAM write strobe/address, registered full, almost-full, fill level and sticky overflow.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned AF_MARGIN = 4
) (
  input  logic                 w_clk_i,
  input  logic                 w_rst_i,
  input  logic                 w_inc_i,
  input  logic [ADDR_SIZE:0]   wq2_rptr_i,
  input  logic                 w_ovf_clr_i,
  output logic                 w_en_o,
  output logic [ADDR_SIZE-1:0] w_addr_o,
  output logic [ADDR_SIZE:0]   w_ptr_o,
  output logic                 w_full_o,
  output logic                 w_almost_full_o,
  output logic [ADDR_SIZE:0]   w_level_o,
  output logic                 w_overflow_o
);

  localparam int unsigned      DEPTH     = fifo_depth(ADDR_SIZE);
  localparam logic [ADDR_SIZE:0] AF_THRESH = (ADDR_SIZE + 1)'(DEPTH - AF_MARGIN);

  logic [ADDR_SIZE:0] w_bin_q,   w_bin_d;
  logic [ADDR_SIZE:0] w_gray_q,  w_gray_d;
  logic [ADDR_SIZE:0] w_level_q, w_level_d;
  logic               w_full_q,  w_full_d;
  logic               w_af_q,    w_af_d;
  logic               w_ovf_q,   w_ovf_d;

  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] rptr_full_cmp;
  logic [31:0]        bin_wide;
  logic [31:0]        gray_wide;

  fifo_gray2bin #(
    .WIDTH(ADDR_SIZE + 1)
  ) u_rptr_g2b (
    .gray_i(wq2_rptr_i),
    .bin_o (rbin)
  );

  assign w_en_o = w_inc_i & ~w_full_q;

  // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
  assign rptr_full_cmp = {~wq2_rptr_i[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr_i[ADDR_SIZE-2:0]};

  always_comb begin
    w_bin_d  = w_bin_q + {{ADDR_SIZE{1'b0}}, w_en_o};
    bin_wide = '0;
    bin_wide[ADDR_SIZE:0] = w_bin_d;
    gray_wide = bin2gray(bin_wide);
    w_gray_d  = gray_wide[ADDR_SIZE:0];
    w_full_d  = (w_gray_d == rptr_full_cmp);
    w_level_d = w_bin_d - rbin;
    w_af_d    = (w_level_d >= AF_THRESH);
    // Set has priority over clear so a rejected write is never lost.
    w_ovf_d   = (w_inc_i & w_full_q) | (w_ovf_q & ~w_ovf_clr_i);
  end

  always_ff @(posedge w_clk_i or negedge w_rst_i) begin
    if (!w_rst_i) begin
      w_bin_q   <= '0;
      w_gray_q  <= '0;
      w_level_q <= '0;
      w_full_q  <= 1'b0;
      w_af_q    <= 1'b0;
      w_ovf_q   <= 1'b0;
    end else begin
      w_bin_q   <= w_bin_d;
      w_gray_q  <= w_gray_d;
      w_level_q <= w_level_d;
      w_full_q  <= w_full_d;
      w_af_q    <= w_af_d;
      w_ovf_q   <= w_ovf_d;
    end
  end

  assign w_addr_o        = w_bin_q[ADDR_SIZE-1:0];
  assign w_ptr_o         = w_gray_q;
  assign w_full_o        = w_full_q;
  assign w_almost_full_o = w_af_q;
  assign w_level_o       = w_level_q;
  assign w_overflow_o    = w_ovf_q;

endmodule
